multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory wait timeout with sticky fault, and a saturating retired-instruction count.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        signal_regRead,
    output logic        signal_regWrite,
    output logic        signal_regDst,
    output logic        signal_memRead,
    output logic        signal_memWrite,
    output logic        signal_memToReg,
    output logic        signal_aluSrc,
    output logic        signal_branch,
    output logic        signal_jump,
    output logic        ir_write,
    output logic        pc_write,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal_instr,
    output logic        mem_fault,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;
    logic        retire;
    logic [7:0]  wait_inc;
    logic        is_r, is_imm, is_load, is_store, is_br;
    logic        is_j, is_halt, supported;
    logic [3:0]  alu_sel;

    assign is_r      = (opcode == 6'h00);
    assign is_imm    = (opcode == 6'h08) || (opcode == 6'h0C) || (opcode == 6'h0D);
    assign is_load   = (opcode == 6'h23) || (opcode == 6'h24) || (opcode == 6'h25);
    assign is_store  = (opcode == 6'h2B);
    assign is_br     = (opcode == 6'h04) || (opcode == 6'h05);
    assign is_j      = (opcode == 6'h02);
    assign is_halt   = (opcode == 6'h3F);
    assign supported = is_r || is_imm || is_load || is_store || is_br;
    assign wait_inc  = wait_q + 8'd1;

    always_comb begin
        alu_sel = ALU_ADD;
        unique case (1'b1)
            is_r: begin
                case (funct)
                    6'h22:   alu_sel = ALU_SUB;
                    6'h24:   alu_sel = ALU_AND;
                    6'h25:   alu_sel = ALU_OR;
                    6'h2A:   alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
            end
            is_br:               alu_sel = ALU_SUB;
            (opcode == 6'h0C):   alu_sel = ALU_AND;
            (opcode == 6'h0D):   alu_sel = ALU_OR;
            default:             alu_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = 8'd0;
        fault_d         = fault_q;
        retire          = 1'b0;
        signal_regRead  = 1'b0;
        signal_regWrite = 1'b0;
        signal_regDst   = 1'b0;
        signal_memRead  = 1'b0;
        signal_memWrite = 1'b0;
        signal_memToReg = 1'b0;
        signal_aluSrc   = 1'b0;
        signal_branch   = 1'b0;
        signal_jump     = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        alu_op          = ALU_ADD;
        illegal_instr   = 1'b0;
        case (state_q)
            S_FETCH: begin
                signal_memRead = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_inc == TIMEOUT) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                signal_regRead = 1'b1;
                if (is_j) begin
                    signal_jump = 1'b1;
                    pc_write    = 1'b1;
                    retire      = 1'b1;
                    state_d     = S_FETCH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (supported) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                signal_aluSrc = is_imm || is_load || is_store;
                alu_op        = alu_sel;
                if (is_br) begin
                    signal_branch = 1'b1;
                    retire        = 1'b1;
                    state_d       = S_FETCH;
                end else if (is_r || is_imm) begin
                    state_d = S_WB;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                signal_memRead  = is_load;
                signal_memWrite = is_store;
                if (mem_ready) begin
                    retire  = is_store;
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (wait_inc == TIMEOUT) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB: begin
                signal_regWrite = 1'b1;
                signal_regDst   = is_r;
                signal_memToReg = is_load;
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Reset must silence every strobe immediately, even mid-MEMORY.
        if (reset) begin
            signal_regRead  = 1'b0;
            signal_regWrite = 1'b0;
            signal_regDst   = 1'b0;
            signal_memRead  = 1'b0;
            signal_memWrite = 1'b0;
            signal_memToReg = 1'b0;
            signal_aluSrc   = 1'b0;
            signal_branch   = 1'b0;
            signal_jump     = 1'b0;
            ir_write        = 1'b0;
            pc_write        = 1'b0;
            alu_op          = ALU_ADD;
            illegal_instr   = 1'b0;
        end
    end

    assign count_d = (retire && (count_q != 32'hFFFF_FFFF)) ? count_q + 32'd1 : count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign state       = state_q;
    assign mem_fault   = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: instruction flows, ALU decode,
// memory wait/timeout, illegal/halt handling and asynchronous reset abort.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        signal_regRead, signal_regWrite, signal_regDst;
    logic        signal_memRead, signal_memWrite, signal_memToReg;
    logic        signal_aluSrc, signal_branch, signal_jump;
    logic        ir_write, pc_write;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic        illegal_instr, mem_fault;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready),
        .signal_regRead(signal_regRead), .signal_regWrite(signal_regWrite),
        .signal_regDst(signal_regDst), .signal_memRead(signal_memRead),
        .signal_memWrite(signal_memWrite), .signal_memToReg(signal_memToReg),
        .signal_aluSrc(signal_aluSrc), .signal_branch(signal_branch),
        .signal_jump(signal_jump), .ir_write(ir_write), .pc_write(pc_write),
        .alu_op(alu_op), .state(state), .illegal_instr(illegal_instr),
        .mem_fault(mem_fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // regWrite only in WRITEBACK, memWrite only in MEMORY
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((signal_regWrite && state !== 3'd4) || (signal_memWrite && state !== 3'd3)) begin
                failures++;
                $display("FAIL strobe_scope state=%0d regWrite=%0b memWrite=%0b", state, signal_regWrite, signal_memWrite);
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (signal_memRead !== 1'b0) begin failures++; $display("FAIL rst_memRead got=%0b exp=0", signal_memRead); end
        checks++; if (ir_write !== 1'b0 || pc_write !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%0b%0b exp=00", ir_write, pc_write); end
        checks++; if (instr_count !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", instr_count); end
        checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", mem_fault); end
        reset = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || signal_memRead !== 1'b1) begin failures++; $display("FAIL rel_fetch state=%0d memRead=%0b exp=0/1", state, signal_memRead); end
    endtask

    task automatic test_rtype_add();
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        #1;
        checks++; if (ir_write !== 1'b1 || pc_write !== 1'b1) begin failures++; $display("FAIL rt_fetch_strobe got=%0b%0b exp=11", ir_write, pc_write); end
        nxt(); mem_ready = 1'b0;
        checks++; if (state !== 3'd1 || signal_regRead !== 1'b1) begin failures++; $display("FAIL rt_decode state=%0d regRead=%0b exp=1/1", state, signal_regRead); end
        nxt();
        checks++; if (state !== 3'd2 || alu_op !== 4'd0 || signal_aluSrc !== 1'b0) begin failures++; $display("FAIL rt_exec state=%0d alu=%0d src=%0b exp=2/0/0", state, alu_op, signal_aluSrc); end
        nxt();
        checks++; if (state !== 3'd4 || signal_regWrite !== 1'b1 || signal_regDst !== 1'b1) begin failures++; $display("FAIL rt_wb state=%0d rw=%0b rd=%0b exp=4/1/1", state, signal_regWrite, signal_regDst); end
        nxt(); ecount = 1;
        checks++; if (state !== 3'd0 || signal_regWrite !== 1'b0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL rt_retire state=%0d rw=%0b cnt=%0d exp=0/0/%0d", state, signal_regWrite, instr_count, ecount); end
    endtask

    task automatic test_lw_wait();
        opcode = 6'h23; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        nxt();
        checks++; if (state !== 3'd2 || signal_aluSrc !== 1'b1 || alu_op !== 4'd0) begin failures++; $display("FAIL lw_exec state=%0d src=%0b alu=%0d exp=2/1/0", state, signal_aluSrc, alu_op); end
        for (int i = 0; i < 3; i++) begin
            nxt();
            if (i == 2) mem_ready = 1'b1;
            checks++; if (state !== 3'd3 || signal_memRead !== 1'b1) begin failures++; $display("FAIL lw_mem%0d state=%0d memRead=%0b exp=3/1", i, state, signal_memRead); end
        end
        nxt(); mem_ready = 1'b0;
        checks++; if (state !== 3'd4 || signal_memToReg !== 1'b1 || signal_regDst !== 1'b0 || signal_regWrite !== 1'b1) begin failures++; $display("FAIL lw_wb state=%0d m2r=%0b rd=%0b rw=%0b exp=4/1/0/1", state, signal_memToReg, signal_regDst, signal_regWrite); end
        nxt(); ecount++;
        checks++; if (state !== 3'd0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL lw_retire state=%0d cnt=%0d exp=0/%0d", state, instr_count, ecount); end
    endtask

    task automatic test_sw();
        opcode = 6'h2B; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        nxt();
        checks++; if (state !== 3'd2 || signal_memWrite !== 1'b0 || signal_aluSrc !== 1'b1) begin failures++; $display("FAIL sw_exec state=%0d mw=%0b src=%0b exp=2/0/1", state, signal_memWrite, signal_aluSrc); end
        nxt(); mem_ready = 1'b1;
        checks++; if (state !== 3'd3 || signal_memWrite !== 1'b1 || signal_memRead !== 1'b0) begin failures++; $display("FAIL sw_mem state=%0d mw=%0b mr=%0b exp=3/1/0", state, signal_memWrite, signal_memRead); end
        nxt(); mem_ready = 1'b0; ecount++;
        checks++; if (state !== 3'd0 || signal_memWrite !== 1'b0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL sw_retire state=%0d mw=%0b cnt=%0d exp=0/0/%0d", state, signal_memWrite, instr_count, ecount); end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        ops[0] = 6'h04; ops[1] = 6'h05;
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i]; mem_ready = 1'b1;
            nxt(); mem_ready = 1'b0;
            nxt();
            checks++; if (state !== 3'd2 || signal_branch !== 1'b1 || alu_op !== 4'd1) begin failures++; $display("FAIL br%0d_exec state=%0d br=%0b alu=%0d exp=2/1/1", i, state, signal_branch, alu_op); end
            nxt(); ecount++;
            checks++; if (state !== 3'd0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL br%0d_retire state=%0d cnt=%0d exp=0/%0d", i, state, instr_count, ecount); end
        end
    endtask

    task automatic test_alu_decode();
        logic [5:0] op [8];
        logic [5:0] fn [8];
        logic [3:0] ex [8];
        op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D};
        fn = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h3F, 6'h00, 6'h22};
        ex = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd2, 4'd3};
        for (int i = 0; i < 8; i++) begin
            opcode = op[i]; funct = fn[i]; mem_ready = 1'b1;
            nxt(); mem_ready = 1'b0;
            nxt();
            checks++; if (state !== 3'd2 || alu_op !== ex[i] || signal_aluSrc !== (op[i] != 6'h00)) begin failures++; $display("FAIL alu%0d state=%0d alu=%0d src=%0b exp=2/%0d/%0b", i, state, alu_op, signal_aluSrc, ex[i], op[i] != 6'h00); end
            nxt();
            checks++; if (state !== 3'd4 || signal_regDst !== (op[i] == 6'h00) || signal_memToReg !== 1'b0) begin failures++; $display("FAIL alu%0d_wb state=%0d rd=%0b m2r=%0b exp=4/%0b/0", i, state, signal_regDst, signal_memToReg, op[i] == 6'h00); end
            nxt(); ecount++;
        end
        checks++; if (instr_count !== 32'(ecount)) begin failures++; $display("FAIL alu_count got=%0d exp=%0d", instr_count, ecount); end
    endtask

    task automatic test_jump();
        opcode = 6'h02; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        checks++; if (state !== 3'd1 || signal_jump !== 1'b1 || pc_write !== 1'b1) begin failures++; $display("FAIL j_decode state=%0d jump=%0b pcw=%0b exp=1/1/1", state, signal_jump, pc_write); end
        nxt(); ecount++;
        checks++; if (state !== 3'd0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL j_retire state=%0d cnt=%0d exp=0/%0d", state, instr_count, ecount); end
    endtask

    task automatic test_illegal();
        opcode = 6'h3E; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        checks++; if (state !== 3'd1 || illegal_instr !== 1'b1) begin failures++; $display("FAIL ill_decode state=%0d ill=%0b exp=1/1", state, illegal_instr); end
        nxt();
        checks++; if (state !== 3'd0 || illegal_instr !== 1'b0 || instr_count !== 32'(ecount)) begin failures++; $display("FAIL ill_return state=%0d ill=%0b cnt=%0d exp=0/0/%0d", state, illegal_instr, instr_count, ecount); end
    endtask

    task automatic test_timeout_edge_ok();
        opcode = 6'h3E; mem_ready = 1'b0;
        repeat (14) nxt();
        checks++; if (state !== 3'd0 || mem_fault !== 1'b0) begin failures++; $display("FAIL to_ok_wait state=%0d fault=%0b exp=0/0", state, mem_fault); end
        mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        checks++; if (state !== 3'd1 || mem_fault !== 1'b0) begin failures++; $display("FAIL to_ok_decode state=%0d fault=%0b exp=1/0", state, mem_fault); end
        nxt();
    endtask

    task automatic test_reset_mid_sw();
        opcode = 6'h2B; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        nxt();
        nxt();
        checks++; if (state !== 3'd3 || signal_memWrite !== 1'b1) begin failures++; $display("FAIL rsw_mem state=%0d mw=%0b exp=3/1", state, signal_memWrite); end
        reset = 1'b1;
        #1;
        checks++; if (signal_memWrite !== 1'b0 || signal_regWrite !== 1'b0) begin failures++; $display("FAIL rsw_abort mw=%0b rw=%0b exp=0/0", signal_memWrite, signal_regWrite); end
        checks++; if (state !== 3'd0 || instr_count !== 32'd0) begin failures++; $display("FAIL rsw_state state=%0d cnt=%0d exp=0/0", state, instr_count); end
        nxt();
        reset = 1'b0;
        #1;
        ecount = 0;
        checks++; if (state !== 3'd0 || signal_memRead !== 1'b1) begin failures++; $display("FAIL rsw_release state=%0d mr=%0b exp=0/1", state, signal_memRead); end
    endtask

    task automatic test_halt_opcode();
        opcode = 6'h3F; mem_ready = 1'b1;
        nxt(); mem_ready = 1'b0;
        nxt();
        checks++; if (state !== 3'd5 || mem_fault !== 1'b0 || signal_memRead !== 1'b0) begin failures++; $display("FAIL halt_enter state=%0d fault=%0b mr=%0b exp=5/0/0", state, mem_fault, signal_memRead); end
        mem_ready = 1'b1;
        nxt();
        checks++; if (state !== 3'd5 || ir_write !== 1'b0 || pc_write !== 1'b0) begin failures++; $display("FAIL halt_stay state=%0d irw=%0b pcw=%0b exp=5/0/0", state, ir_write, pc_write); end
        mem_ready = 1'b0;
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_timeout_fault();
        opcode = 6'h00; mem_ready = 1'b0;
        repeat (14) nxt();
        checks++; if (state !== 3'd0 || mem_fault !== 1'b0) begin failures++; $display("FAIL tf_wait state=%0d fault=%0b exp=0/0", state, mem_fault); end
        nxt();
        checks++; if (state !== 3'd5 || mem_fault !== 1'b1) begin failures++; $display("FAIL tf_halt state=%0d fault=%0b exp=5/1", state, mem_fault); end
        mem_ready = 1'b1;
        #1;
        checks++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || signal_memRead !== 1'b0) begin failures++; $display("FAIL tf_quiet irw=%0b pcw=%0b mr=%0b exp=0/0/0", ir_write, pc_write, signal_memRead); end
        nxt();
        nxt();
        checks++; if (state !== 3'd5 || mem_fault !== 1'b1) begin failures++; $display("FAIL tf_sticky state=%0d fault=%0b exp=5/1", state, mem_fault); end
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (mem_fault !== 1'b0 || state !== 3'd0) begin failures++; $display("FAIL tf_reset fault=%0b state=%0d exp=0/0", mem_fault, state); end
        nxt();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; mem_ready = 1'b0;
        nxt();
        nxt();
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_sw();
        test_branch();
        test_alu_decode();
        test_jump();
        test_illegal();
        test_timeout_edge_ok();
        test_reset_mid_sw();
        test_halt_opcode();
        test_timeout_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
